// File: rtl/tile_blit_engine.sv
// Tile blitter: expands fill/clear/border commands into one-per-cycle writes on the tile bus,
// forwarding CPU writes when idle. Border op is built only with TILE_BLIT_BORDER_EN defined.
module tile_blit_engine #(
    parameter int BASE_ADDR = 2048,
    parameter int COLS      = 10,
    parameter int ROWS      = 10,
    parameter int STRIDE    = 4
) (
    input  logic        clk_cpu,
    input  logic        reset_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [3:0]  x0,
    input  logic [3:0]  y0,
    input  logic [3:0]  w,
    input  logic [3:0]  h,
    input  logic [7:0]  color,
    input  logic [31:0] cpu_addr,
    input  logic [7:0]  cpu_data,
    input  logic        cpu_we,
    output logic        cpu_stall,
    output logic [31:0] addr,
    output logic [7:0]  datain,
    output logic        DM_W,
    output logic        busy,
    output logic        done,
    output logic        err
);

`ifdef TILE_BLIT_BORDER_EN
    localparam logic BORDER_SUPPORTED = 1'b1;
`else
    localparam logic BORDER_SUPPORTED = 1'b0;
`endif

    localparam logic [1:0] OP_CLEAR  = 2'b01;
    localparam logic [1:0] OP_BORDER = 2'b10;
    localparam logic [1:0] OP_RSVD   = 2'b11;
    localparam logic [4:0] COLS5     = 5'(COLS);
    localparam logic [4:0] ROWS5     = 5'(ROWS);

    typedef enum logic [1:0] {IDLE, SETUP, WRITE, FIN} state_t;

    state_t      state, state_next;

    logic [1:0]  op_q;
    logic [3:0]  x0_q, y0_q, w_q, h_q;
    logic [7:0]  color_q;
    logic [4:0]  xs_q, xe_q, ys_q, ye_q;
    logic [4:0]  cx, cy;
    logic        last_q;
    logic [31:0] eng_addr;
    logic [7:0]  eng_data;
    logic        eng_we;
    logic        err_q;

    logic [4:0]  x_sum, y_sum;
    logic [4:0]  sx0, sxe, sy0, sye;
    logic [4:0]  bx0, bxe, by0, bye;
    logic [4:0]  px, py, nx, ny, x_inc;
    logic        reject, border_mode, interior_row, is_last, issue;
    logic [31:0] tile_addr;

    // Clipping and raster walk; in SETUP the walk starts from the freshly clipped bounds
    // so the first write can be issued on the SETUP edge.
    always_comb begin
        x_sum = {1'b0, x0_q} + {1'b0, w_q};
        y_sum = {1'b0, y0_q} + {1'b0, h_q};
        if (op_q == OP_CLEAR) begin
            sx0 = 5'd0;
            sxe = COLS5;
            sy0 = 5'd0;
            sye = ROWS5;
        end else begin
            sx0 = {1'b0, x0_q};
            sxe = (x_sum > COLS5) ? COLS5 : x_sum;
            sy0 = {1'b0, y0_q};
            sye = (y_sum > ROWS5) ? ROWS5 : y_sum;
        end
        reject = (op_q == OP_RSVD)
              || ((op_q == OP_BORDER) && !BORDER_SUPPORTED)
              || ((op_q != OP_CLEAR) && ((w_q == 4'd0) || (h_q == 4'd0)
                  || ({1'b0, x0_q} >= COLS5) || ({1'b0, y0_q} >= ROWS5)));
        if (state == SETUP) begin
            bx0 = sx0;
            bxe = sxe;
            by0 = sy0;
            bye = sye;
            px  = sx0;
            py  = sy0;
        end else begin
            bx0 = xs_q;
            bxe = xe_q;
            by0 = ys_q;
            bye = ye_q;
            px  = cx;
            py  = cy;
        end
        border_mode  = BORDER_SUPPORTED && (op_q == OP_BORDER);
        is_last      = (px == bxe - 5'd1) && (py == bye - 5'd1);
        interior_row = (py != by0) && (py != bye - 5'd1);
        x_inc        = px + 5'd1;
        nx           = x_inc;
        ny           = py;
        // On interior rows of a border, jump straight from the left edge to the right edge.
        if (border_mode && interior_row && (px == bx0) && (bxe > bx0 + 5'd1)) begin
            nx = bxe - 5'd1;
        end else if (x_inc >= bxe) begin
            nx = bx0;
            ny = py + 5'd1;
        end
        tile_addr = 32'(BASE_ADDR) + (32'(py) * 32'(COLS) + 32'(px)) * 32'(STRIDE);
    end

    always_ff @(posedge clk_cpu or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        issue      = 1'b0;
        case (state)
            IDLE:  if (cmd_valid) state_next = SETUP;
            SETUP: begin
                if (reject) begin
                    state_next = IDLE;
                end else begin
                    state_next = WRITE;
                    issue      = 1'b1;
                end
            end
            WRITE: begin
                if (last_q) state_next = FIN;
                else        issue      = 1'b1;
            end
            FIN:     state_next = IDLE;
            default: state_next = IDLE;
        endcase

        cmd_ready = (state == IDLE);
        busy      = (state != IDLE);
        done      = (state == FIN);
        err       = err_q;
        cpu_stall = busy && cpu_we;
        if (state == IDLE) begin
            addr   = cpu_addr;
            datain = cpu_data;
            DM_W   = cpu_we;
        end else begin
            addr   = eng_addr;
            datain = eng_data;
            DM_W   = eng_we;
        end
    end

    // Command capture and registered engine bus; last_q marks the write currently on the bus as final.
    always_ff @(posedge clk_cpu or negedge reset_n) begin
        if (!reset_n) begin
            op_q     <= 2'd0;
            x0_q     <= 4'd0;
            y0_q     <= 4'd0;
            w_q      <= 4'd0;
            h_q      <= 4'd0;
            color_q  <= 8'd0;
            xs_q     <= 5'd0;
            xe_q     <= 5'd0;
            ys_q     <= 5'd0;
            ye_q     <= 5'd0;
            cx       <= 5'd0;
            cy       <= 5'd0;
            last_q   <= 1'b0;
            eng_addr <= 32'd0;
            eng_data <= 8'd0;
            eng_we   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            err_q  <= (state == SETUP) && reject;
            eng_we <= issue;
            if ((state == IDLE) && cmd_valid) begin
                op_q    <= cmd_op;
                x0_q    <= x0;
                y0_q    <= y0;
                w_q     <= w;
                h_q     <= h;
                color_q <= color;
            end
            if (state == SETUP) begin
                xs_q <= sx0;
                xe_q <= sxe;
                ys_q <= sy0;
                ye_q <= sye;
            end
            if (issue) begin
                eng_addr <= tile_addr;
                eng_data <= color_q;
                cx       <= nx;
                cy       <= ny;
                last_q   <= is_last;
            end
        end
    end

endmodule

// File: tb/tb_tile_blit_engine.sv
// Directed self-checking bench for tile_blit_engine; write traces are captured per command
// and compared with hand-computed tile addresses and completion timing.
module tb_tile_blit_engine;

    logic        clk_cpu = 1'b0;
    logic        reset_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [3:0]  x0, y0, w, h;
    logic [7:0]  color;
    logic [31:0] cpu_addr;
    logic [7:0]  cpu_data;
    logic        cpu_we;
    logic        cpu_stall;
    logic [31:0] addr;
    logic [7:0]  datain;
    logic        DM_W;
    logic        busy;
    logic        done;
    logic        err;

    int          checks = 0;
    int          failures = 0;

    logic [31:0] wr_addr [0:127];
    logic [7:0]  wr_data [0:127];
    int          wr_cnt, first_j, done_j, err_j, done_cnt, err_cnt;
    int          stall_cnt, stall_bad, leak_cnt, ready_after, pulse_after;
    int          bad;

    logic [31:0] exp_fill [0:5];
    logic [31:0] exp_border [0:7];

    tile_blit_engine dut (
        .clk_cpu   (clk_cpu),
        .reset_n   (reset_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .x0        (x0),
        .y0        (y0),
        .w         (w),
        .h         (h),
        .color     (color),
        .cpu_addr  (cpu_addr),
        .cpu_data  (cpu_data),
        .cpu_we    (cpu_we),
        .cpu_stall (cpu_stall),
        .addr      (addr),
        .datain    (datain),
        .DM_W      (DM_W),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 clk_cpu = ~clk_cpu;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, observed, expected);
        end
    endtask

    // Issues one command (accepted at edge N), then samples every negedge; j=0 is the cycle after edge N.
    task automatic applyStimulus(input logic [1:0] op, input logic [3:0] ax, input logic [3:0] ay,
                                 input logic [3:0] aw, input logic [3:0] ah, input logic [7:0] col,
                                 input int limit);
        @(negedge clk_cpu);
        cmd_op = op; x0 = ax; y0 = ay; w = aw; h = ah; color = col;
        cmd_valid = 1'b1;
        @(posedge clk_cpu);
        #1 cmd_valid = 1'b0;
        wr_cnt = 0; first_j = -1; done_j = -1; err_j = -1; done_cnt = 0; err_cnt = 0;
        stall_cnt = 0; stall_bad = 0; leak_cnt = 0;
        for (int j = 0; j < limit; j++) begin
            @(negedge clk_cpu);
            if (busy && cpu_we && cpu_stall) stall_cnt++;
            if (busy && cpu_we && !cpu_stall) stall_bad++;
            if (busy && cpu_we && (addr == cpu_addr)) leak_cnt++;
            if (DM_W) begin
                if (wr_cnt == 0) first_j = j;
                if (wr_cnt < 128) begin
                    wr_addr[wr_cnt] = addr;
                    wr_data[wr_cnt] = datain;
                end
                wr_cnt++;
            end
            if (done) begin done_cnt++; done_j = j; end
            if (err) begin err_cnt++; err_j = j; end
            if (done || err) break;
        end
        @(negedge clk_cpu);
        ready_after = int'(cmd_ready);
        pulse_after = int'(done || err);
    endtask

    initial begin
        exp_fill   = '{32'd2176, 32'd2180, 32'd2184, 32'd2216, 32'd2220, 32'd2224};
        exp_border = '{32'd2048, 32'd2052, 32'd2056, 32'd2088, 32'd2096, 32'd2128, 32'd2132, 32'd2136};

        reset_n = 1'b0; cmd_valid = 1'b0; cmd_op = 2'b00;
        x0 = 4'd0; y0 = 4'd0; w = 4'd0; h = 4'd0; color = 8'd0;
        cpu_addr = 32'd0; cpu_data = 8'd0; cpu_we = 1'b0;

        #12;
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_done", done, 0);
        checkOutput("reset_err", err, 0);
        checkOutput("reset_dmw", DM_W, 0);
        @(negedge clk_cpu);
        reset_n = 1'b1;
        #1 checkOutput("reset_ready", cmd_ready, 1);

        $display("[TB] fill rect");
        applyStimulus(2'b00, 4'd2, 4'd3, 4'd3, 4'd2, 8'hE0, 40);
        checkOutput("fill_count", wr_cnt, 6);
        checkOutput("fill_first_cycle", first_j, 1);
        for (int i = 0; i < 6; i++) checkOutput($sformatf("fill_addr%0d", i), wr_addr[i], exp_fill[i]);
        checkOutput("fill_data_first", wr_data[0], 8'hE0);
        checkOutput("fill_data_last", wr_data[5], 8'hE0);
        checkOutput("fill_done_cycle", done_j, 7);
        checkOutput("fill_no_err", err_cnt, 0);
        checkOutput("fill_ready_after", ready_after, 1);
        checkOutput("fill_pulse_once", pulse_after, 0);

        $display("[TB] clipping");
        applyStimulus(2'b00, 4'd8, 4'd9, 4'd5, 4'd5, 8'h5A, 40);
        checkOutput("clip_count", wr_cnt, 2);
        checkOutput("clip_addr0", wr_addr[0], 2440);
        checkOutput("clip_addr1", wr_addr[1], 2444);
        checkOutput("clip_done_cycle", done_j, 3);

        $display("[TB] clear all");
        applyStimulus(2'b01, 4'd7, 4'd7, 4'd0, 4'd0, 8'h00, 200);
        checkOutput("clear_count", wr_cnt, 100);
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            if (wr_addr[i] !== 32'(2048 + 4 * i) || wr_data[i] !== 8'h00) bad++;
        end
        checkOutput("clear_sequence_errors", bad, 0);
        checkOutput("clear_done_cycle", done_j, 101);

        $display("[TB] rejects");
        applyStimulus(2'b00, 4'd1, 4'd1, 4'd0, 4'd2, 8'hFF, 20);
        checkOutput("rej_w0_err_cycle", err_j, 1);
        checkOutput("rej_w0_writes", wr_cnt, 0);
        checkOutput("rej_w0_done", done_cnt, 0);
        applyStimulus(2'b11, 4'd1, 4'd1, 4'd2, 4'd2, 8'hFF, 20);
        checkOutput("rej_op3_err_cycle", err_j, 1);
        checkOutput("rej_op3_writes", wr_cnt, 0);
        applyStimulus(2'b00, 4'd10, 4'd0, 4'd2, 4'd2, 8'hFF, 20);
        checkOutput("rej_x_oob_err", err_cnt, 1);
        checkOutput("rej_x_oob_writes", wr_cnt, 0);

`ifdef TILE_BLIT_BORDER_EN
        $display("[TB] border");
        applyStimulus(2'b10, 4'd0, 4'd0, 4'd3, 4'd3, 8'h03, 40);
        checkOutput("border_count", wr_cnt, 8);
        for (int i = 0; i < 8; i++) checkOutput($sformatf("border_addr%0d", i), wr_addr[i], exp_border[i]);
        checkOutput("border_done_cycle", done_j, 9);
`else
        $display("[TB] border op without feature");
        applyStimulus(2'b10, 4'd0, 4'd0, 4'd3, 4'd3, 8'h03, 20);
        checkOutput("border_rej_err_cycle", err_j, 1);
        checkOutput("border_rej_writes", wr_cnt, 0);
`endif

        $display("[TB] cpu arbitration");
        @(negedge clk_cpu);
        cpu_we = 1'b1; cpu_addr = 32'd2084; cpu_data = 8'h1C;
        #1;
        checkOutput("idle_fwd_dmw", DM_W, 1);
        checkOutput("idle_fwd_addr", addr, 2084);
        checkOutput("idle_fwd_data", datain, 8'h1C);
        checkOutput("idle_no_stall", cpu_stall, 0);
        applyStimulus(2'b00, 4'd2, 4'd3, 4'd3, 4'd2, 8'hE0, 40);
        checkOutput("busy_stall_cycles", stall_cnt, 8);
        checkOutput("busy_stall_missing", stall_bad, 0);
        checkOutput("busy_cpu_leak", leak_cnt, 0);
        checkOutput("busy_write_count", wr_cnt, 6);
        checkOutput("busy_addr0", wr_addr[0], 2176);
        cpu_we = 1'b0;

        $display("[TB] reset mid command");
        @(negedge clk_cpu);
        cmd_op = 2'b01; color = 8'h11; cmd_valid = 1'b1;
        @(posedge clk_cpu);
        #1 cmd_valid = 1'b0;
        wr_cnt = 0;
        for (int j = 0; j < 20; j++) begin
            @(negedge clk_cpu);
            if (DM_W) wr_cnt++;
            if (wr_cnt == 3) break;
        end
        checkOutput("abort_reached_third", wr_cnt, 3);
        reset_n = 1'b0;
        #1;
        checkOutput("abort_dmw_drop", DM_W, 0);
        checkOutput("abort_busy_drop", busy, 0);
        repeat (2) @(negedge clk_cpu);
        reset_n = 1'b1;
        wr_cnt = 0; done_cnt = 0;
        for (int j = 0; j < 6; j++) begin
            @(negedge clk_cpu);
            if (DM_W) wr_cnt++;
            if (done) done_cnt++;
        end
        checkOutput("abort_no_writes", wr_cnt, 0);
        checkOutput("abort_no_done", done_cnt, 0);
        checkOutput("abort_ready", cmd_ready, 1);

        $display("[TB] single tile corner");
        applyStimulus(2'b00, 4'd9, 4'd9, 4'd1, 4'd1, 8'hA5, 20);
        checkOutput("corner_count", wr_cnt, 1);
        checkOutput("corner_addr", wr_addr[0], 2444);
        checkOutput("corner_data", wr_data[0], 8'hA5);
        checkOutput("corner_done_cycle", done_j, 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/tile_blit_engine.md
Name: tile_blit_engine

Overview:
- Bus-master stage that sits directly upstream of the VGA tile display.
- Accepts rectangle-fill and clear commands on the 10x10 tile colour field and expands each command into a sequence of one-per-cycle byte writes on the tile write bus (addr, datain, DM_W).
- When idle, it forwards CPU data-memory writes unchanged to the same bus.
- While a command runs, it owns the bus and stalls the CPU.

Parameters:
- BASE_ADDR, 2048: byte address of tile 0.
- COLS, 10: tiles per row.
- ROWS, 10: tile rows.
- STRIDE, 4: byte spacing between consecutive tiles.

Ports:
- clk_cpu  in  1  CPU clock; every flop uses this clock.
- reset_n  in  1  reset, asynchronous, active-low.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  high in IDLE only.
- cmd_op  in  2  00 = fill rect, 01 = clear all, 10 = border, 11 = reserved.
- x0  in  4  left column.
- y0  in  4  top row.
- w  in  4  width in tiles.
- h  in  4  height in tiles.
- color  in  8  RGB332 fill value.
- cpu_addr  in  32  CPU write address.
- cpu_data  in  8  CPU write data.
- cpu_we  in  1  CPU write strobe.
- cpu_stall  out  1  CPU must hold its write.
- addr  out  32  tile bus address.
- datain  out  8  tile bus data.
- DM_W  out  1  tile bus write strobe.
- busy  out  1  command in progress.
- done  out  1  one-cycle pulse at command completion.
- err  out  1  one-cycle pulse on a rejected command.

Behaviour:
- Reset (reset_n low, asynchronous):
  - FSM goes to IDLE.
  - Engine copies of addr/datain/DM_W are cleared to 0.
  - busy=0, done=0, err=0.
  - cmd_ready=1 on release.
- Reset mid-command aborts immediately: DM_W drops in the same instant, no further writes occur, and done does not pulse.
- FSM states: IDLE -> SETUP -> WRITE -> FIN -> IDLE.
- IDLE:
  - cmd_ready=1, busy=0, cpu_stall=0.
  - The bus is a combinational pass-through: addr=cpu_addr, datain=cpu_data, DM_W=cpu_we.
  - A command is accepted on the clk_cpu edge where cmd_valid && cmd_ready; its fields are latched at that edge.
- SETUP (1 cycle):
  - Clip: xe = min(x0+w, COLS), ye = min(y0+h, ROWS). Arithmetic is 5-bit so x0+w cannot wrap.
  - Reject the command if any of these hold: w==0, h==0, x0>=COLS, y0>=ROWS, or op==11.
  - On reject: err pulses 1 cycle, no writes, return to IDLE.
  - Op 01 ignores x0/y0/w/h and uses the full field (0,0)-(COLS,ROWS).
- WRITE:
  - One write per cycle, raster order: x increments first, then y.
  - addr = BASE_ADDR + (y*COLS + x)*STRIDE; datain = color; DM_W = 1.
  - Engine outputs are registered, so the first DM_W is in cycle N+2 when the command is accepted at edge N.
  - Number of writes = (xe-x0)*(ye-y0).
  - The last write happens at x=xe-1, y=ye-1; the next state is FIN.
- FIN (1 cycle): DM_W=0, done=1, then IDLE with cmd_ready=1.
- busy=1 and cpu_stall=cpu_we in SETUP, WRITE and FIN. CPU writes are not forwarded while busy.
- cmd_valid while busy is ignored because cmd_ready=0. No queueing.
- cmd_valid and cpu_we together in IDLE: the CPU write is forwarded in that cycle and the command is accepted at the same edge. There is no conflict.
- done and err are never high in the same cycle.

Optional Feature:
- Macro: TILE_BLIT_BORDER_EN.
- Defined: op 10 writes only the perimeter tiles of the clipped rectangle (x==x0, x==xe-1, y==y0 or y==ye-1).
  - Interior positions are skipped with no bus cycle, so the write count equals the number of perimeter tiles.
  - A 1-wide or 1-high rectangle degenerates to a full fill.
- Undefined: op 10 is rejected like op 11, with an err pulse and no writes.

Test Plan:
- Fill rect: op=00, x0=2, y0=3, w=3, h=2, color=0xE0, accepted at edge N.
  -> DM_W at cycles N+2..N+7, addr 2176, 2180, 2184, 2216, 2220, 2224, datain=0xE0.
  -> done pulses at N+8; cmd_ready=1 at N+9.
- Clipping: op=00, x0=8, y0=9, w=5, h=5.
  -> exactly 2 writes, addr 2440 then 2444.
- Clear all: op=01, color=0x00.
  -> 100 writes, addr 2048..2444 step 4; done 102 cycles after acceptance.
- Reject: op=00, w=0; also op=11.
  -> err pulses at N+2, no DM_W, done stays 0.
- CPU arbitration:
  -> cpu_we=1, cpu_addr=2084, cpu_data=0x1C while busy: cpu_stall=1 and addr never shows 2084 from the CPU.
  -> Same write in IDLE: appears on addr/datain/DM_W in the same cycle.
- Reset and border:
  -> Drop reset_n during the 3rd write of the clear-all: DM_W=0 immediately, no done, cmd_ready=1 after release.
  -> With TILE_BLIT_BORDER_EN, op=10, x0=0, y0=0, w=3, h=3: 8 writes, addr 2092 is skipped.
